maxnet_nn_param: RTL and testbench

- Parametrised successor to the fixed 4-input Maxnet: finds the winner among N_INPUTS signed fixed-point values by iterative lateral inhibition.
- Each iteration applies a_i <- relu(a_i - EPSILON*(sum_j a_j - a_i)) to every activation in parallel.
- Reports the winner's original value and index, the iteration count, and timeout/no-winner flags.
- Sits under the top level as the compute core, driven by the start_signal/done handshake.

---
 rtl/maxnet_nn_param.sv | 149 ++++++++++++++
 tb/tb_maxnet_nn_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/maxnet_nn_param.sv
// Parametrised Maxnet core: iterative lateral inhibition over N signed
// fixed-point inputs, reporting the surviving winner's original value.
module maxnet_nn_param #(
  parameter int N_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS = 16,
  parameter logic [DATA_WIDTH-1:0] EPSILON = 'h3333,
  parameter int MAX_ITER = 64,
  localparam int IW = ($clog2(N_INPUTS) < 1) ? 1 : $clog2(N_INPUTS),
  localparam int CW = $clog2(MAX_ITER + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start_signal,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] input_numbers,
  output logic [DATA_WIDTH-1:0]        output_maximum_number,
  output logic [IW-1:0]                output_maximum_index,
  output logic [CW-1:0]                iteration_count,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic                         no_winner
);

  localparam int SW = DATA_WIDTH + $clog2(N_INPUTS);
  localparam int PW = DATA_WIDTH + SW;
  localparam int NZW = $clog2(N_INPUTS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITERATE,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] act [N_INPUTS];
  logic [DATA_WIDTH-1:0] orig [N_INPUTS];
  logic [DATA_WIDTH-1:0] act_nxt [N_INPUTS];

  logic [SW-1:0]  sum;
  logic [SW-1:0]  diff;
  logic [PW-1:0]  prod;
  logic [PW:0]    delta;
  logic [NZW-1:0] nz;
  logic [IW-1:0]  low_idx;
  logic           load;
  logic           step;
  logic           finish;

  assign busy = (state == ITERATE);
  assign done = (state == DONE);

  always_comb begin
    sum = '0;
    nz = '0;
    low_idx = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      sum = sum + SW'(act[i]);
      if (act[i] != '0) begin
        nz = nz + NZW'(1);
        low_idx = IW'(i);
      end
    end
  end

  // Activations are never negative, so the inhibition term is unsigned
  // and a borrow out of the subtraction means the result clamps to 0.
  always_comb begin
    diff = '0;
    prod = '0;
    delta = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      diff = sum - SW'(act[i]);
      prod = PW'(EPSILON) * PW'(diff);
      delta = (PW+1)'(act[i]) - (PW+1)'(prod >> FRAC_BITS);
      act_nxt[i] = delta[PW] ? '0 : delta[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    load = 1'b0;
    step = 1'b0;
    finish = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start_signal) begin
          load = 1'b1;
          state_nxt = ITERATE;
        end
      end
      ITERATE: begin
        if (nz <= NZW'(1) || iteration_count == CW'(MAX_ITER)) begin
          finish = 1'b1;
          state_nxt = DONE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      iteration_count <= '0;
      output_maximum_number <= '0;
      output_maximum_index <= '0;
      timeout <= 1'b0;
      no_winner <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) begin
        act[i] <= '0;
        orig[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (load) begin
        iteration_count <= '0;
        output_maximum_number <= '0;
        output_maximum_index <= '0;
        timeout <= 1'b0;
        no_winner <= 1'b0;
        for (int i = 0; i < N_INPUTS; i++) begin
          orig[i] <= input_numbers[i*DATA_WIDTH +: DATA_WIDTH];
          act[i] <= input_numbers[i*DATA_WIDTH+DATA_WIDTH-1] ? '0 :
                    input_numbers[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (step) begin
        iteration_count <= iteration_count + CW'(1);
        for (int i = 0; i < N_INPUTS; i++) begin
          act[i] <= act_nxt[i];
        end
      end else if (finish) begin
        if (nz == '0) begin
          no_winner <= 1'b1;
          output_maximum_number <= '0;
          output_maximum_index <= '0;
        end else begin
          output_maximum_index <= low_idx;
          output_maximum_number <= orig[low_idx];
          timeout <= (nz != NZW'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_maxnet_nn_param.sv
// Directed bench for maxnet_nn_param: default 4-input core plus an
// 8-input instance with a smaller inhibition weight.
module tb_maxnet_nn_param;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] in4;
  logic [31:0]  num;
  logic [1:0]   idx;
  logic [6:0]   cnt;
  logic         busy, done, tmo, nw;

  logic         start8;
  logic [255:0] in8;
  logic [31:0]  num8;
  logic [2:0]   idx8;
  logic [6:0]   cnt8;
  logic         busy8, done8, tmo8, nw8;

  int n_chk = 0;
  int n_fail = 0;
  int cyc;

  always #5 clock = ~clock;

  maxnet_nn_param u_dut (
    .clock(clock), .reset(reset), .start_signal(start),
    .input_numbers(in4), .output_maximum_number(num),
    .output_maximum_index(idx), .iteration_count(cnt),
    .busy(busy), .done(done), .timeout(tmo), .no_winner(nw)
  );

  maxnet_nn_param #(
    .N_INPUTS(8), .EPSILON(32'h0000_1000)
  ) u_dut8 (
    .clock(clock), .reset(reset), .start_signal(start8),
    .input_numbers(in8), .output_maximum_number(num8),
    .output_maximum_index(idx8), .iteration_count(cnt8),
    .busy(busy8), .done(done8), .timeout(tmo8), .no_winner(nw8)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input bit wide, output int c);
    c = 0;
    while (((wide ? done8 : done) == 1'b0) && c < 100) begin
      @(posedge clock);
      #1;
      c++;
    end
    if (c >= 100) chk("wait_bound", c, 0);
  endtask

  task automatic go4(input logic [127:0] v, output int c);
    in4 = v;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    wait_done(1'b0, c);
  endtask

  function automatic logic [127:0] pk4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  initial begin
    reset = 1'b0;
    start = 1'b0;
    start8 = 1'b0;
    in4 = '0;
    in8 = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_num", num, 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_flags", 32'({tmo, nw}), 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    go4(pk4(32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0), cyc);
    chk("t1_latency", cyc, 4);
    chk("t1_idx", 32'(idx), 0);
    chk("t1_num", num, 32'h0001_0000);
    chk("t1_cnt", 32'(cnt), 3);
    chk("t1_flags", 32'({tmo, nw}), 0);
    chk("t1_busy", 32'(busy), 0);

    go4(pk4(32'hFFFE_0000, 32'h0000_C000, 32'hFFFF_0000, 32'h0), cyc);
    chk("t2_latency", cyc, 1);
    chk("t2_idx", 32'(idx), 1);
    chk("t2_num", num, 32'h0000_C000);
    chk("t2_cnt", 32'(cnt), 0);
    chk("t2_flags", 32'({tmo, nw}), 0);

    go4(pk4(32'h0000_8000, 32'h0000_8000, 32'h0000_199A, 32'h0), cyc);
    chk("tie_latency", cyc, 65);
    chk("tie_cnt", 32'(cnt), 64);
    chk("tie_timeout", 32'(tmo), 1);
    chk("tie_nw", 32'(nw), 0);
    chk("tie_idx", 32'(idx), 0);
    chk("tie_num", num, 32'h0000_8000);

    go4(pk4(32'hFFFF_0000, 32'h0, 32'hFFFB_0000, 32'h0), cyc);
    chk("neg_latency", cyc, 1);
    chk("neg_nw", 32'(nw), 1);
    chk("neg_tmo", 32'(tmo), 0);
    chk("neg_num", num, 0);
    chk("neg_idx", 32'(idx), 0);

    in4 = pk4(32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("mid_nw_cleared", 32'(nw), 0);
    @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("mid_ignore_cnt", 32'(cnt), 2);
    chk("mid_ignore_busy", 32'(busy), 1);
    chk("mid_ignore_done", 32'(done), 0);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_cnt", 32'(cnt), 0);
    chk("abort_num_idx", num | 32'(idx), 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    go4(pk4(32'h0, 32'h0, 32'h0, 32'h0003_0000), cyc);
    chk("post_latency", cyc, 1);
    chk("post_idx", 32'(idx), 3);
    chk("post_num", num, 32'h0003_0000);

    for (int i = 0; i < 8; i++) in8[i*32 +: 32] = 32'(i + 1) << 16;
    start8 = 1'b1;
    @(posedge clock);
    #1;
    start8 = 1'b0;
    chk("n8_busy", 32'(busy8), 1);
    wait_done(1'b1, cyc);
    chk("n8_idx", 32'(idx8), 7);
    chk("n8_num", num8, 32'h0008_0000);
    chk("n8_flags", 32'({tmo8, nw8}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
